// File: rtl/hf_reader_pkg.sv
// Shared types and constants for the ISO14443-A reader frame sequencer.
package hf_reader_pkg;

    // Carrier output stage mode codes, shared with the pwr_hi mode mux
    localparam logic [2:0] READER_LISTEN = 3'b011;
    localparam logic [2:0] READER_MOD    = 3'b100;

    // One Miller bit period in carrier cycles
    localparam int BIT_PERIOD = 128;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SOF,
        ST_TX,
        ST_EOF,
        ST_GUARD,
        ST_LISTEN,
        ST_DONE
    } state_e;

    // One TX byte with its framing info, used for both shifter and holding register
    typedef struct packed {
        logic       last;
        logic [3:0] nbits;
        logic [8:0] data;   // {parity, byte}, sent LSB first
    } tx_ent_t;

    // Bit count 0 means 1, anything above 9 means 9
    function automatic logic [3:0] clamp_bits(input logic [3:0] b);
        if (b == 4'd0) return 4'd1;
        if (b > 4'd9)  return 4'd9;
        return b;
    endfunction

endpackage

// File: rtl/hf_reader_seq_miller_enc.sv
// Modified-Miller encoder: bit-period phase counter, previous-bit memory and
// registered pause output (one cycle behind the phase counter).
module miller_enc
    import hf_reader_pkg::*;
#(
    parameter int PAUSE_CYCLES = 32
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic kill_i,       // force pause off and freeze (abort)
    input  logic sof_i,        // frame start: zero phase, prev = 0
    input  logic bit_valid_i,  // a bit period is being coded
    input  logic bit_i,        // logical bit of the current period
    input  logic eof_y_i,      // closing Y of EOF: never pause
    output logic mod_sig_o,
    output logic bit_done_o
);

    logic [6:0] phase_q, phase_d;
    logic       prev_q, prev_d;
    logic       mod_q, mod_d;
    logic       pause;

    assign bit_done_o = bit_valid_i && (phase_q == 7'(BIT_PERIOD - 1));
    assign mod_sig_o  = mod_q;

    // Pause window selection (X / Z / Y) and phase/prev bookkeeping
    always_comb begin
        phase_d = phase_q;
        prev_d  = prev_q;
        pause   = 1'b0;
        if (eof_y_i)
            pause = 1'b0;
        else if (bit_i)
            pause = (phase_q >= 7'd64) && (int'(phase_q) < 64 + PAUSE_CYCLES);
        else if (!prev_q)
            pause = int'(phase_q) < PAUSE_CYCLES;
        mod_d = bit_valid_i && pause && !kill_i;
        if (sof_i) begin
            phase_d = '0;
            prev_d  = 1'b0;
        end else if (bit_valid_i) begin
            phase_d = phase_q + 7'd1;
            if (bit_done_o) prev_d = bit_i;
        end
    end

    // Encoder state, updated on the carrier falling edge like the rest of the HF path
    always_ff @(negedge clk_i) begin
        if (rst_i) begin
            phase_q <= '0;
            prev_q  <= 1'b0;
            mod_q   <= 1'b0;
        end else begin
            phase_q <= phase_d;
            prev_q  <= prev_d;
            mod_q   <= mod_d;
        end
    end

endmodule

// File: rtl/hf_reader_seq.sv
// Reader-side ISO14443-A frame sequencer: sends a Miller frame, waits the
// frame-delay guard, then gathers detector samples into bytes.
// RX bytes start at the first modulated sample; windows before the tag answers
// are counted for the timeout but never packed into bytes.
module hf_reader_seq
    import hf_reader_pkg::*;
#(
    parameter int PAUSE_CYCLES       = 32,
    parameter int GUARD_CYCLES       = 1088,
    parameter int RX_IDLE_WINDOWS    = 32,
    parameter int RX_TIMEOUT_WINDOWS = 1024
) (
    input  logic       osc_clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] tx_byte,
    input  logic       tx_par,
    input  logic [3:0] tx_bits,
    input  logic       tx_last,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       rx_strobe,
    input  logic       rx_curbit,
    output logic [2:0] mod_type,
    output logic       mod_sig,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       busy,
    output logic       done,
    output logic       rx_timeout,
    output logic       tx_underrun
);

    localparam int GW = $clog2(GUARD_CYCLES + 1);
    localparam int IW = $clog2(RX_IDLE_WINDOWS + 1);
    localparam int TW = $clog2(RX_TIMEOUT_WINDOWS + 1);

    state_e        state_q, state_d;
    tx_ent_t       cur_q, cur_d, hold_q, hold_d, in_ent;
    logic          hold_vld_q, hold_vld_d;
    logic          eof2_q, eof2_d;
    logic [GW-1:0] guard_q, guard_d;
    logic [7:0]    acc_q, acc_d, acc_n;
    logic [2:0]    nsamp_q, nsamp_d;
    logic          seen_q, seen_d;
    logic [IW-1:0] idle_q, idle_d;
    logic [TW-1:0] win_q, win_d;
    logic [7:0]    rx_byte_q, rx_byte_d;
    logic          rx_valid_q, rx_valid_d;
    logic          done_q, done_d;
    logic [2:0]    mtype_q, mtype_d;
    logic          tmo_q, tmo_d, und_q, und_d;
    logic          start_ok, active, hs, cur_bit, bit_done, rx_end;

    assign start_ok = start && tx_valid && (state_q == ST_IDLE) && !abort;
    assign active   = state_q inside {ST_SOF, ST_TX, ST_EOF};
    assign tx_ready = (state_q == ST_TX) && !hold_vld_q;
    assign hs       = tx_ready && tx_valid;
    assign cur_bit  = (state_q == ST_TX) ? cur_q.data[0] : 1'b0;
    assign in_ent   = {tx_last, clamp_bits(tx_bits), tx_par, tx_byte};

    miller_enc #(.PAUSE_CYCLES(PAUSE_CYCLES)) u_enc (
        .clk_i       (osc_clk),
        .rst_i       (rst),
        .kill_i      (abort),
        .sof_i       (start_ok),
        .bit_valid_i (active),
        .bit_i       (cur_bit),
        .eof_y_i     ((state_q == ST_EOF) && eof2_q),
        .mod_sig_o   (mod_sig),
        .bit_done_o  (bit_done)
    );

    // Frame FSM, TX byte pipeline, guard timer and RX packing
    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
        eof2_d     = eof2_q;
        guard_d    = guard_q;
        acc_d      = acc_q;
        nsamp_d    = nsamp_q;
        seen_d     = seen_q;
        idle_d     = idle_q;
        win_d      = win_q;
        rx_byte_d  = rx_byte_q;
        rx_valid_d = 1'b0;
        tmo_d      = tmo_q;
        und_d      = und_q;
        rx_end     = 1'b0;
        acc_n      = {acc_q[6:0], rx_curbit};
        unique case (state_q)
            ST_IDLE: if (start_ok) begin
                state_d    = ST_SOF;
                cur_d      = in_ent;
                hold_vld_d = 1'b0;
                tmo_d      = 1'b0;
                und_d      = 1'b0;
                acc_d      = '0;
                nsamp_d    = '0;
                seen_d     = 1'b0;
                idle_d     = '0;
                win_d      = '0;
            end
            ST_SOF: if (bit_done) state_d = ST_TX;
            ST_TX: if (bit_done) begin
                if (cur_q.nbits > 4'd1) begin
                    cur_d.data  = cur_q.data >> 1;
                    cur_d.nbits = cur_q.nbits - 4'd1;
                end else if (cur_q.last) begin
                    state_d = ST_EOF;
                    eof2_d  = 1'b0;
                end else if (hold_vld_q) begin
                    cur_d      = hold_q;
                    hold_vld_d = 1'b0;
                end else begin
                    und_d   = 1'b1;
                    state_d = ST_EOF;
                    eof2_d  = 1'b0;
                end
            end
            ST_EOF: if (bit_done) begin
                if (eof2_q) begin
                    state_d = ST_GUARD;
                    guard_d = '0;
                end else begin
                    eof2_d = 1'b1;
                end
            end
            ST_GUARD: begin
                if (guard_q == GW'(GUARD_CYCLES - 1)) state_d = ST_LISTEN;
                else guard_d = guard_q + GW'(1);
            end
            ST_LISTEN: if (rx_strobe) begin
                if (rx_curbit || seen_q) begin
                    acc_d   = acc_n;
                    nsamp_d = nsamp_q + 3'd1;
                    if (nsamp_q == 3'd7) begin
                        rx_byte_d  = acc_n;
                        rx_valid_d = 1'b1;
                        acc_d      = '0;
                    end
                end
                if (rx_curbit) begin
                    seen_d = 1'b1;
                    idle_d = '0;
                end else if (seen_q) begin
                    idle_d = idle_q + IW'(1);
                    if (idle_q == IW'(RX_IDLE_WINDOWS - 1)) rx_end = 1'b1;
                end else begin
                    win_d = win_q + TW'(1);
                    if (win_q == TW'(RX_TIMEOUT_WINDOWS - 1)) begin
                        rx_end = 1'b1;
                        tmo_d  = 1'b1;
                    end
                end
                if (rx_end) begin
                    state_d = ST_DONE;
                    // flush a partial byte, earliest sample in the MSB
                    if (seen_q && nsamp_q != 3'd7) begin
                        rx_byte_d  = acc_n << (3'd7 - nsamp_q);
                        rx_valid_d = 1'b1;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // a load in the same cycle as a transfer lands after it
        if (hs) begin
            hold_d     = in_ent;
            hold_vld_d = 1'b1;
        end
        if (abort) begin
            state_d    = ST_IDLE;
            rx_valid_d = 1'b0;
        end
        done_d  = (state_q == ST_DONE) && !abort;
        mtype_d = (active && !abort) ? READER_MOD : READER_LISTEN;
    end

    // State registers on the carrier falling edge
    always_ff @(negedge osc_clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cur_q      <= '0;
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
            eof2_q     <= 1'b0;
            guard_q    <= '0;
            acc_q      <= '0;
            nsamp_q    <= '0;
            seen_q     <= 1'b0;
            idle_q     <= '0;
            win_q      <= '0;
            rx_byte_q  <= '0;
            rx_valid_q <= 1'b0;
            done_q     <= 1'b0;
            mtype_q    <= READER_LISTEN;
            tmo_q      <= 1'b0;
            und_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_q      <= cur_d;
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
            eof2_q     <= eof2_d;
            guard_q    <= guard_d;
            acc_q      <= acc_d;
            nsamp_q    <= nsamp_d;
            seen_q     <= seen_d;
            idle_q     <= idle_d;
            win_q      <= win_d;
            rx_byte_q  <= rx_byte_d;
            rx_valid_q <= rx_valid_d;
            done_q     <= done_d;
            mtype_q    <= mtype_d;
            tmo_q      <= tmo_d;
            und_q      <= und_d;
        end
    end

    assign mod_type    = mtype_q;
    assign rx_byte     = rx_byte_q;
    assign rx_valid    = rx_valid_q;
    assign busy        = (state_q != ST_IDLE);
    assign done        = done_q;
    assign rx_timeout  = tmo_q;
    assign tx_underrun = und_q;

endmodule

// File: tb/tb_hf_reader_seq.sv
// Directed bench for hf_reader_seq: Miller waveforms checked cycle by cycle
// against hand-derived pause offsets, then RX packing, timeout, abort and reset.
module tb_hf_reader_seq;

    logic       osc_clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0;
    logic [7:0] tx_byte = 8'h00;
    logic       tx_par = 1'b0, tx_last = 1'b0, tx_valid = 1'b0;
    logic [3:0] tx_bits = 4'd0;
    logic       rx_strobe = 1'b0, rx_curbit = 1'b0;
    logic       tx_ready, mod_sig, rx_valid, busy, done, rx_timeout, tx_underrun;
    logic [2:0] mod_type;
    logic [7:0] rx_byte;

    int         checks = 0, errors = 0;
    int         done_cnt = 0;
    logic       busy_at_done = 1'b0;
    logic [7:0] rxq[$];
    int         pz[$];
    int         mod_end = 0;

    hf_reader_seq dut (
        .osc_clk(osc_clk), .rst(rst), .start(start), .abort(abort),
        .tx_byte(tx_byte), .tx_par(tx_par), .tx_bits(tx_bits), .tx_last(tx_last),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_strobe(rx_strobe),
        .rx_curbit(rx_curbit), .mod_type(mod_type), .mod_sig(mod_sig),
        .rx_byte(rx_byte), .rx_valid(rx_valid), .busy(busy), .done(done),
        .rx_timeout(rx_timeout), .tx_underrun(tx_underrun)
    );

    always #5 osc_clk = ~osc_clk;

    // Log RX bytes and done pulses (DUT updates on negedge, read on posedge)
    always @(posedge osc_clk) begin
        if (rx_valid) rxq.push_back(rx_byte);
        if (done) begin
            done_cnt++;
            busy_at_done = busy;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] qget(input int i);
        if (i < rxq.size()) return rxq[i];
        return 8'hEE;
    endfunction

    task automatic send_start(input logic [7:0] b, input logic p, input logic [3:0] n, input logic last);
        @(posedge osc_clk);
        tx_byte = b; tx_par = p; tx_bits = n; tx_last = last; tx_valid = 1'b1; start = 1'b1;
        @(posedge osc_clk);
        start = 1'b0; tx_valid = 1'b0;
    endtask

    // Sample offsets 0..len-1 (offset 0 = first SOF pause cycle) and compare
    // mod_sig/mod_type with the pause list in pz and the MOD window end.
    task automatic capture(input int len, input int hs_at, input int bs_at);
        int   bad = 0, first = -1;
        logic es;
        logic [2:0] et;
        for (int k = 0; k < len; k++) begin
            @(posedge osc_clk);
            es = 1'b0;
            foreach (pz[i]) if (k >= pz[i] && k < pz[i] + 32) es = 1'b1;
            et = (k < mod_end) ? 3'b100 : 3'b011;
            if (mod_sig !== es || mod_type !== et) begin
                bad++;
                if (first < 0) first = k;
            end
            if (k == hs_at) begin
                chk("tx_ready_before_load", tx_ready, 1);
                tx_byte = 8'h20; tx_bits = 4'd8; tx_last = 1'b1; tx_valid = 1'b1;
            end
            if (k == hs_at + 1 && hs_at >= 0) begin
                chk("tx_ready_after_load", tx_ready, 0);
                tx_valid = 1'b0;
            end
            if (k == bs_at) begin
                tx_byte = 8'hFF; tx_bits = 4'd9; tx_valid = 1'b1; start = 1'b1;
            end
            if (k == bs_at + 1 && bs_at >= 0) begin
                start = 1'b0; tx_valid = 1'b0;
            end
        end
        checks++;
        assert (bad == 0) else begin
            errors++;
            $error("FAIL waveform %0d bad cycles, first at offset %0d, expected 0", bad, first);
        end
    endtask

    task automatic strobe(input logic b);
        rx_strobe = 1'b1; rx_curbit = b;
        @(posedge osc_clk);
        rx_strobe = 1'b0; rx_curbit = 1'b0;
        repeat (15) @(posedge osc_clk);
    endtask

    initial begin
        // ---- reset state
        repeat (3) @(posedge osc_clk);
        chk("rst_mod_type", mod_type, 3'b011);
        chk("rst_mod_sig", mod_sig, 0);
        chk("rst_tx_ready", tx_ready, 0);
        chk("rst_rx_byte", rx_byte, 0);
        chk("rst_busy_done_valid", {busy, done, rx_valid}, 0);
        chk("rst_flags", {rx_timeout, tx_underrun}, 0);
        rst = 1'b0;

        // ---- REQA 0x26/7 bits, guard boundary, RX 1111_0000 x2 then silence
        send_start(8'h26, 1'b0, 4'd7, 1'b1);
        pz = '{0, 128, 320, 448, 640, 832, 1024};
        mod_end = 1280;
        capture(1280 + 1087, -1, -1);
        strobe(1'b1);                       // last GUARD cycle: must be ignored
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < 8; i++) strobe(i < 4);
        for (int i = 0; i < 32; i++) strobe(1'b0);
        repeat (4) @(posedge osc_clk);
        chk("reqa_rx_count", rxq.size(), 6);
        chk("reqa_rx_byte0", qget(0), 8'hF0);
        chk("reqa_rx_byte1", qget(1), 8'hF0);
        chk("reqa_rx_tail", qget(2) | qget(3) | qget(4) | qget(5), 8'h00);
        chk("reqa_done_cnt", done_cnt, 1);
        chk("reqa_busy_at_done", busy_at_done, 0);
        chk("reqa_flags", {rx_timeout, tx_underrun}, 0);
        rxq.delete();

        // ---- two bytes 0x93, 0x20 via handshake, then RX timeout
        send_start(8'h93, 1'b0, 4'd8, 1'b0);
        pz = '{0, 192, 320, 512, 704, 896, 1088, 1280, 1408, 1536, 1664, 1856, 2048, 2176};
        mod_end = 2432;
        capture(2432 + 1087, 300, -1);
        @(posedge osc_clk);
        for (int i = 0; i < 1023; i++) strobe(1'b0);
        chk("tmo_busy_before_last_window", busy, 1);
        chk("tmo_no_done_early", done_cnt, 1);
        strobe(1'b0);
        repeat (2) @(posedge osc_clk);
        chk("tmo_done_cnt", done_cnt, 2);
        chk("tmo_rx_timeout", rx_timeout, 1);
        chk("tmo_underrun", tx_underrun, 0);
        chk("tmo_no_rx_valid", rxq.size(), 0);

        // ---- tx_bits=0 (one bit), non-last, no next byte -> underrun
        send_start(8'hA5, 1'b0, 4'd0, 1'b0);
        chk("start_clears_flags", {rx_timeout, tx_underrun}, 0);
        pz = '{0, 192};
        mod_end = 512;
        capture(512 + 1087, -1, -1);
        @(posedge osc_clk);
        strobe(1'b1); strobe(1'b0); strobe(1'b1);
        for (int i = 0; i < 32; i++) strobe(1'b0);
        repeat (4) @(posedge osc_clk);
        chk("und_flag", tx_underrun, 1);
        chk("und_done_cnt", done_cnt, 3);
        chk("und_rx_count_with_flush", rxq.size(), 5);
        chk("und_rx_byte0", qget(0), 8'hA0);
        chk("und_rx_timeout", rx_timeout, 0);
        rxq.delete();

        // ---- tx_bits=15 (nine bits, parity=1), then reset during LISTEN
        send_start(8'h00, 1'b1, 4'd15, 1'b1);
        pz = '{0, 128, 256, 384, 512, 640, 768, 896, 1024, 1216};
        mod_end = 1536;
        capture(1536 + 1087, -1, -1);
        @(posedge osc_clk);
        for (int i = 0; i < 8; i++) strobe(1'b1);
        chk("listen_rx_byte_ff", rx_byte, 8'hFF);
        rst = 1'b1;
        @(posedge osc_clk);
        rst = 1'b0;
        chk("rst_listen_busy", busy, 0);
        chk("rst_listen_mod", {mod_type, mod_sig}, {3'b011, 1'b0});
        chk("rst_listen_rx_byte", rx_byte, 8'h00);
        repeat (40) @(posedge osc_clk);
        chk("rst_listen_no_done", done_cnt, 3);

        // ---- start while busy ignored; abort inside a pause, with start
        send_start(8'h26, 1'b0, 4'd7, 1'b1);
        pz = '{0, 128, 320, 448, 640, 832, 1024};
        mod_end = 1280;
        capture(330, -1, 200);
        abort = 1'b1; start = 1'b1; tx_valid = 1'b1;
        @(posedge osc_clk);
        abort = 1'b0; start = 1'b0; tx_valid = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_mod_sig", mod_sig, 0);
        chk("abort_mod_type", mod_type, 3'b011);
        repeat (20) @(posedge osc_clk);
        chk("abort_stays_idle", {busy, mod_sig}, 0);
        chk("abort_no_done", done_cnt, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
